// File: rtl/ts_gen.sv
// Training-sequence (TS1/TS2) ordered-set generator: latches TS fields on ts_update
// and issues paced ts_valid strobes, stalling on downstream FIFO backpressure.
module ts_gen #(
   parameter logic [7:0]  COM_SYM  = 8'hBC,
   parameter logic [7:0]  TS1_ID   = 8'h4A,
   parameter logic [7:0]  TS2_ID   = 8'h45,
   parameter int unsigned GEN1_GAP = 64,
   parameter int unsigned GEN2_GAP = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   ts_info,
   input  logic         ts_update,
   input  logic         ts_stop,
   input  logic         speed,
   input  logic         ts_type,
   input  logic [7:0]   link_num,
   input  logic [7:0]   lane_num,
   input  logic [7:0]   n_fts,
   input  logic [7:0]   train_ctrl,
   input  logic [7:0]   ts_target,
   input  logic         ts_tx_fifo_full,
   output logic         ts_valid,
   output logic [127:0] ts,
   output logic [7:0]   ts_sent_cnt,
   output logic         ts_sent_enough,
   output logic [7:0]   ts_state
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] GAP   = 2'd2;
   localparam logic [1:0] STALL = 2'd3;

   localparam int unsigned GW = 16;

   logic [1:0]    state_q, state_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [127:0]  ts_q, ts_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [7:0]    target_q, target_d;
   logic [7:0]    info_q, info_d;
   logic          loaded_q, loaded_d;

   function automatic logic [7:0] rate_id(input logic spd);
      return spd ? 8'h06 : 8'h02;
   endfunction

   always_comb begin
      state_d  = state_q;
      gap_d    = gap_q;
      ts_d     = ts_q;
      cnt_d    = cnt_q;
      target_d = target_q;
      info_d   = info_q;
      loaded_d = loaded_q;
      ts_valid = (state_q == ISSUE) && !ts_tx_fifo_full;

      case (state_q)
         ISSUE: begin
            if (ts_tx_fifo_full) begin
               state_d = STALL;
            end else begin
               state_d = GAP;
               gap_d   = speed ? GW'(GEN2_GAP - 2) : GW'(GEN1_GAP - 2);
            end
         end
         GAP: begin
            // Rate symbol is refreshed only on the gap->issue transition, so a stall
            // replays exactly the content that was about to go out.
            if (gap_q == '0) begin
               state_d      = ISSUE;
               ts_d[39:32]  = rate_id(speed);
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         STALL: begin
            if (!ts_tx_fifo_full) state_d = ISSUE;
         end
         default: ;
      endcase

      if (ts_valid && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;

      // Stop dominates update; an update's count clear overrides a same-cycle increment.
      if (ts_stop) begin
         state_d = IDLE;
      end else if (ts_update) begin
         state_d       = ISSUE;
         gap_d         = '0;
         cnt_d         = '0;
         loaded_d      = 1'b1;
         target_d      = ts_target;
         info_d        = ts_info;
         ts_d[7:0]     = COM_SYM;
         ts_d[15:8]    = link_num;
         ts_d[23:16]   = lane_num;
         ts_d[31:24]   = n_fts;
         ts_d[39:32]   = rate_id(speed);
         ts_d[47:40]   = train_ctrl;
         for (int unsigned k = 6; k < 16; k++) begin
            ts_d[8*k +: 8] = ts_type ? TS2_ID : TS1_ID;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         gap_q    <= '0;
         ts_q     <= '0;
         cnt_q    <= '0;
         target_q <= '0;
         info_q   <= '0;
         loaded_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         gap_q    <= gap_d;
         ts_q     <= ts_d;
         cnt_q    <= cnt_d;
         target_q <= target_d;
         info_q   <= info_d;
         loaded_q <= loaded_d;
      end
   end

   assign ts             = ts_q;
   assign ts_sent_cnt    = cnt_q;
   assign ts_sent_enough = loaded_q && (cnt_q >= target_q);
   assign ts_state       = info_q;

endmodule

// File: tb/tb_ts_gen.sv
// Scoreboard bench for ts_gen: expected strobes (cycle + content) are queued when
// stimulus is applied and compared as the DUT issues them.
module tb_ts_gen;

   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   ts_info, link_num, lane_num, n_fts, train_ctrl, ts_target;
   logic         ts_update, ts_stop, speed, ts_type, ts_tx_fifo_full;
   logic         ts_valid;
   logic [127:0] ts;
   logic [7:0]   ts_sent_cnt;
   logic         ts_sent_enough;
   logic [7:0]   ts_state;

   typedef struct {
      int unsigned  cyc;
      logic [127:0] ts;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int unsigned cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ts_gen #(
      .COM_SYM(8'hBC), .TS1_ID(8'h4A), .TS2_ID(8'h45), .GEN1_GAP(64), .GEN2_GAP(32)
   ) dut (
      .clk(clk), .rst(rst), .ts_info(ts_info), .ts_update(ts_update), .ts_stop(ts_stop),
      .speed(speed), .ts_type(ts_type), .link_num(link_num), .lane_num(lane_num),
      .n_fts(n_fts), .train_ctrl(train_ctrl), .ts_target(ts_target),
      .ts_tx_fifo_full(ts_tx_fifo_full), .ts_valid(ts_valid), .ts(ts),
      .ts_sent_cnt(ts_sent_cnt), .ts_sent_enough(ts_sent_enough), .ts_state(ts_state)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [127:0] mk_ts(input logic [7:0] link, input logic [7:0] lane,
                                          input logic [7:0] nf, input logic [7:0] trn,
                                          input logic spd, input logic typ);
      logic [127:0] t;
      t[7:0]   = 8'hBC;
      t[15:8]  = link;
      t[23:16] = lane;
      t[31:24] = nf;
      t[39:32] = spd ? 8'h06 : 8'h02;
      t[47:40] = trn;
      for (int k = 6; k < 16; k++) t[8*k +: 8] = typ ? 8'h45 : 8'h4A;
      return t;
   endfunction

   task automatic goto(input int unsigned n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic load(input logic [7:0] info, input logic [7:0] link, input logic [7:0] lane,
                       input logic [7:0] nf, input logic [7:0] trn, input logic [7:0] tgt,
                       input logic typ, input logic spd, output int unsigned k);
      ts_info = info; link_num = link; lane_num = lane; n_fts = nf;
      train_ctrl = trn; ts_target = tgt; ts_type = typ; speed = spd;
      ts_update = 1'b1;
      k = cyc;
      @(posedge clk);
      #1;
      ts_update = 1'b0;
   endtask

   task automatic push_run(input int unsigned k, input int unsigned g, input int unsigned n,
                           input logic [127:0] t);
      for (int unsigned j = 0; j < n; j++) exp_q.push_back('{k + 1 + g * j, t});
   endtask

   task automatic stop_at(input int unsigned n);
      goto(n);
      ts_stop = 1'b1;
      @(posedge clk);
      #1;
      ts_stop = 1'b0;
   endtask

   task automatic check_cnt(input string tag, input logic [7:0] c, input logic e);
      check({tag, "_cnt"}, 128'(ts_sent_cnt), 128'(c));
      check({tag, "_enough"}, 128'(ts_sent_enough), 128'(e));
   endtask

   always @(negedge clk) begin
      if (ts_tx_fifo_full) check("valid_while_full", 128'(ts_valid), 128'(0));
      if (ts_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 128'(ts_valid), 128'(0));
         end else begin
            mon_e = exp_q.pop_front();
            check("valid_cycle", 128'(cyc), 128'(mon_e.cyc));
            check("ts_content", ts, mon_e.ts);
         end
      end
   end

   initial begin
      int unsigned  k, k2, u;
      logic [127:0] t, t2;
      rst = 1'b0; ts_info = '0; link_num = '0; lane_num = '0; n_fts = '0; train_ctrl = '0;
      ts_target = '0; ts_update = 1'b0; ts_stop = 1'b0; speed = 1'b0; ts_type = 1'b0;
      ts_tx_fifo_full = 1'b0;
      goto(3);
      check("rst_valid", 128'(ts_valid), 128'(0));
      check("rst_ts", ts, 128'(0));
      check_cnt("rst", 8'd0, 1'b0);
      check("rst_state", 128'(ts_state), 128'(0));
      rst = 1'b1;
      goto(5);

      // Gen1 TS1, target 16
      load(8'h21, 8'h00, 8'h03, 8'h1F, 8'h02, 8'd16, 1'b0, 1'b0, k);
      t = mk_ts(8'h00, 8'h03, 8'h1F, 8'h02, 1'b0, 1'b0);
      push_run(k, 64, 20, t);
      check("a_state", 128'(ts_state), 128'(8'h21));
      check_cnt("a_load", 8'd0, 1'b0);
      goto(k + 1 + 64 * 15);
      check_cnt("a_p16", 8'd15, 1'b0);
      goto(k + 2 + 64 * 15);
      check_cnt("a_after16", 8'd16, 1'b1);
      stop_at(k + 1 + 64 * 19 + 10);
      goto(cyc + 100);
      check_cnt("a_idle_hold", 8'd20, 1'b1);
      check("a_idle_state", 128'(ts_state), 128'(8'h21));

      // Gen2 TS2, target 8, with a mid-gap reload of lane 7 at count 5
      load(8'h32, 8'h01, 8'h00, 8'h20, 8'h08, 8'd8, 1'b1, 1'b1, k);
      push_run(k, 32, 5, mk_ts(8'h01, 8'h00, 8'h20, 8'h08, 1'b1, 1'b1));
      u = k + 1 + 32 * 4 + 10;
      goto(u);
      check_cnt("b_before_reload", 8'd5, 1'b0);
      load(8'h33, 8'h01, 8'h07, 8'h20, 8'h08, 8'd8, 1'b1, 1'b1, k2);
      t2 = mk_ts(8'h01, 8'h07, 8'h20, 8'h08, 1'b1, 1'b1);
      push_run(k2, 32, 10, t2);
      check_cnt("b_reload", 8'd0, 1'b0);
      check("b_state", 128'(ts_state), 128'(8'h33));
      goto(k2 + 1 + 32 * 7);
      check_cnt("b_p8", 8'd7, 1'b0);
      goto(k2 + 2 + 32 * 7);
      check_cnt("b_after8", 8'd8, 1'b1);
      goto(k2 + 1 + 32 * 9 + 10);
      lane_num = 8'h55; ts_info = 8'h44;
      ts_update = 1'b1; ts_stop = 1'b1;
      @(posedge clk);
      #1;
      ts_update = 1'b0; ts_stop = 1'b0;
      goto(cyc + 100);
      check_cnt("b_stop_wins", 8'd10, 1'b1);
      check("b_stop_state", 128'(ts_state), 128'(8'h33));
      check("b_stop_ts", ts, t2);

      // Backpressure: FIFO full across the due point for 100 cycles
      load(8'h11, 8'h02, 8'h01, 8'h10, 8'h00, 8'd3, 1'b0, 1'b0, k);
      t = mk_ts(8'h02, 8'h01, 8'h10, 8'h00, 1'b0, 1'b0);
      exp_q.push_back('{k + 1, t});
      goto(k + 60);
      ts_tx_fifo_full = 1'b1;
      goto(k + 160);
      ts_tx_fifo_full = 1'b0;
      exp_q.push_back('{k + 161, t});
      exp_q.push_back('{k + 225, t});
      goto(k + 162);
      check_cnt("c_after_stall", 8'd2, 1'b0);
      goto(k + 226);
      check_cnt("c_after_gap", 8'd3, 1'b1);
      stop_at(k + 230);

      // Saturation over 300 TS, then reset mid-gap
      load(8'h55, 8'h03, 8'h02, 8'h00, 8'h01, 8'd255, 1'b0, 1'b1, k);
      push_run(k, 32, 300, mk_ts(8'h03, 8'h02, 8'h00, 8'h01, 1'b1, 1'b0));
      goto(k + 1 + 32 * 254);
      check_cnt("d_p255", 8'd254, 1'b0);
      goto(k + 2 + 32 * 254);
      check_cnt("d_sat", 8'd255, 1'b1);
      goto(k + 2 + 32 * 299);
      check_cnt("d_hold", 8'd255, 1'b1);
      goto(k + 1 + 32 * 299 + 10);
      rst = 1'b0;
      #1;
      check("d_rst_valid", 128'(ts_valid), 128'(0));
      check("d_rst_ts", ts, 128'(0));
      check_cnt("d_rst", 8'd0, 1'b0);
      check("d_rst_state", 128'(ts_state), 128'(0));
      goto(cyc + 3);
      rst = 1'b1;
      goto(cyc + 80);
      check_cnt("d_post_rst", 8'd0, 1'b0);

      // Target 0: enough from the cycle after load
      load(8'h66, 8'h04, 8'h05, 8'h06, 8'h07, 8'd0, 1'b1, 1'b0, k);
      exp_q.push_back('{k + 1, mk_ts(8'h04, 8'h05, 8'h06, 8'h07, 1'b0, 1'b1)});
      check_cnt("e_load", 8'd0, 1'b1);
      goto(k + 3);
      check_cnt("e_one", 8'd1, 1'b1);
      stop_at(k + 5);
      goto(cyc + 20);
      check("queue_empty", 128'(exp_q.size()), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
